// File: rtl/spi_shift_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_shift_engine_pkg
// Description : Shared types and constants for the SPI shift engine. This
//               covers the FSM state encoding and the frame geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_shift_engine_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        PUSH  = 3'd4
    } spi_eng_state_t;

    localparam int SPI_FRAME_BITS = 8;

    // Two SCLK edges per bit; the edge counter must hold 0..2*bits-1
    localparam int SPI_EDGE_CNT_W = 5;

endpackage : spi_shift_engine_pkg
`default_nettype wire

// File: rtl/spi_shift_engine_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module      : spi_sclk_gen
// Description : SCLK divider for the SPI shift engine. While i_run is high,
//               it emits a 1-cycle o_edge_stb every (i_div+1) clk cycles. The
//               first strobe occurs i_div+1 cycles after i_run rises.
//               o_lead is high when the pending edge is a leading (odd) edge
//               and low when it is a trailing (even) edge. All state is
//               cleared while i_run is low.
// Ports       : clk, rst          - clock, async active-high reset
//               i_run             - high while the engine is shifting
//               i_div             - half-period minus one, in clk cycles
//               o_edge_stb        - SCLK edge strobe (1 cycle)
//               o_lead            - strobe refers to a leading edge
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sclk_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_run,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_edge_stb,
    output logic             o_lead
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_lead;

    assign o_edge_stb = i_run && (r_cnt == i_div);
    assign o_lead     = r_lead;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_lead <= 1'b1;
        end else if (!i_run) begin
            r_cnt  <= '0;
            r_lead <= 1'b1;
        end else if (o_edge_stb) begin
            r_cnt  <= '0;
            r_lead <= ~r_lead;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

endmodule : spi_sclk_gen
`default_nettype wire

// File: rtl/spi_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_shift_engine
// Description : SPI master byte engine placed between a TX and an RX FIFO.
//               It pops a byte, shifts it out MSB-first on MOSI, and captures
//               MISO into a byte. It then pushes that byte to the RX FIFO.
//               CS_N stays low across back-to-back bytes.
// Ports       : clk, rst                        - clock, async active-high reset
//               en_i                            - allow new bytes to start
//               cpol_i, cpha_i                  - SPI mode (change only in IDLE)
//               clk_div_i                       - SCLK half-period = div+1 clks
//               tx_fifo_empty_i/data_i/read_o   - TX FIFO pop side
//               rx_fifo_full_i/write_o/data_o   - RX FIFO push side
//               sclk_o, mosi_o, miso_i, cs_n_o  - SPI pins
//               busy_o                          - engine not in IDLE
// Config      : SPI_LOOPBACK_EN - when defined, the sampler reads mosi_o
//               instead of miso_i. The pins still toggle.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_shift_engine
    import spi_shift_engine_pkg::*;
#(
    parameter int DIV_W  = 8,
    parameter int DATA_W = SPI_FRAME_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic [DIV_W-1:0]  clk_div_i,
    input  logic              tx_fifo_empty_i,
    input  logic [DATA_W-1:0] tx_fifo_data_i,
    output logic              tx_fifo_read_o,
    input  logic              rx_fifo_full_i,
    output logic              rx_fifo_write_o,
    output logic [DATA_W-1:0] rx_fifo_data_o,
    output logic              sclk_o,
    output logic              mosi_o,
    input  logic              miso_i,
    output logic              cs_n_o,
    output logic              busy_o
);

    localparam logic [SPI_EDGE_CNT_W-1:0] c_LAST_EDGE = SPI_EDGE_CNT_W'(2*DATA_W - 1);

    spi_eng_state_t            r_state;
    spi_eng_state_t            w_next_state;
    logic [DIV_W-1:0]          r_div;
    logic [DATA_W-1:0]         r_tx_shift;
    logic [DATA_W-1:0]         r_rx_shift;
    logic                      r_mosi;
    logic                      r_sclk_tog;
    logic [SPI_EDGE_CNT_W-1:0] r_edge_cnt;
    logic                      r_cs_n;

    logic w_run;
    logic w_edge_stb;
    logic w_lead;
    logic w_sample;
    logic w_shift;
    logic w_last_edge;
    logic w_sample_src;
    logic w_tx_read;
    logic w_rx_write;
    logic w_cs_n_next;

`ifdef SPI_LOOPBACK_EN
    logic w_unused_miso;
    assign w_unused_miso = miso_i;
    assign w_sample_src  = r_mosi;
`else
    assign w_sample_src  = miso_i;
`endif

    assign w_run = (r_state == SHIFT);

    spi_sclk_gen #(
        .DIV_W (DIV_W)
    ) u_sclk_gen (
        .clk        (clk),
        .rst        (rst),
        .i_run      (w_run),
        .i_div      (r_div),
        .o_edge_stb (w_edge_stb),
        .o_lead     (w_lead)
    );

    // CPHA=0: sample on leading edges, shift on trailing edges except the last.
    // CPHA=1: shift on leading edges, sample on trailing edges.
    assign w_last_edge = w_edge_stb && (r_edge_cnt == c_LAST_EDGE);
    assign w_sample    = w_edge_stb && (cpha_i ? !w_lead : w_lead);
    assign w_shift     = w_edge_stb && (cpha_i ? w_lead : (!w_lead && !w_last_edge));

    // ------------------------------------------------------------------------
    // Next-state and strobe decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_tx_read    = 1'b0;
        w_rx_write   = 1'b0;
        case (r_state)
            IDLE: begin
                if (en_i && !tx_fifo_empty_i) begin
                    w_next_state = FETCH;
                end
            end
            FETCH: begin
                w_tx_read    = 1'b1;
                w_next_state = LOAD;
            end
            LOAD: begin
                w_next_state = SHIFT;
            end
            SHIFT: begin
                if (w_last_edge) begin
                    w_next_state = PUSH;
                end
            end
            PUSH: begin
                if (!rx_fifo_full_i) begin
                    w_rx_write   = 1'b1;
                    w_next_state = (en_i && !tx_fifo_empty_i) ? FETCH : IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        // CS goes low from LOAD onwards. A FETCH that follows a PUSH keeps it
        // low, and a FETCH that follows IDLE leaves it high.
        w_cs_n_next = (w_next_state == IDLE) ||
                      ((w_next_state == FETCH) && (r_state == IDLE));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cs_n  <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_cs_n  <= w_cs_n_next;
        end
    end

    // ------------------------------------------------------------------------
    // Shift / capture datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div      <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_mosi     <= 1'b0;
            r_sclk_tog <= 1'b0;
            r_edge_cnt <= '0;
        end else begin
            if (r_state == LOAD) begin
                r_div      <= clk_div_i;
                r_mosi     <= tx_fifo_data_i[DATA_W-1];
                r_rx_shift <= '0;
                // With CPHA=0, bit7 is already on MOSI. The shifter therefore
                // starts at bit6. With CPHA=1, the first leading edge drives
                // bit7 itself.
                r_tx_shift <= cpha_i ? tx_fifo_data_i
                                     : {tx_fifo_data_i[DATA_W-2:0], 1'b0};
            end
            if (w_run) begin
                if (w_edge_stb) begin
                    r_sclk_tog <= ~r_sclk_tog;
                    r_edge_cnt <= r_edge_cnt + 1'b1;
                end
                if (w_shift) begin
                    r_mosi     <= r_tx_shift[DATA_W-1];
                    r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
                end
                if (w_sample) begin
                    r_rx_shift <= {r_rx_shift[DATA_W-2:0], w_sample_src};
                end
            end else begin
                r_sclk_tog <= 1'b0;
                r_edge_cnt <= '0;
            end
        end
    end

    // SCLK is the idle level XOR an even number of toggles per frame. It
    // therefore returns to cpol_i by itself and follows cpol_i whenever idle.
    assign sclk_o          = cpol_i ^ r_sclk_tog;
    assign mosi_o          = r_mosi;
    assign cs_n_o          = r_cs_n;
    assign busy_o          = (r_state != IDLE);
    assign tx_fifo_read_o  = w_tx_read;
    assign rx_fifo_write_o = w_rx_write;
    assign rx_fifo_data_o  = r_rx_shift;

endmodule : spi_shift_engine
`default_nettype wire
